// File: rtl/teller_sched_pkg.sv
// Shared types and helpers for the teller scheduler: the control-state enum,
// the default teller-id width and a saturating popcount.
package teller_sched_pkg;

  localparam int unsigned T_DEFAULT = 4;
  localparam int unsigned TW        = $clog2(T_DEFAULT);

  typedef enum logic {
    S_READY = 1'b0,
    S_HOLD  = 1'b1
  } ctrl_state_e;

  // Number of set bits in v, clamped to the largest value representable in width bits.
  function automatic int unsigned popcount_sat(input logic [7:0] v, input int unsigned width);
    int unsigned cnt;
    int unsigned lim;
    cnt = 0;
    for (int unsigned b = 0; b < 8; b++) begin
      cnt = cnt + 32'(v[b]);
    end
    lim = (32'd1 << width) - 32'd1;
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage

// File: rtl/teller_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to 0.
module rr_arbiter
  import teller_sched_pkg::*;
#(
  parameter  int unsigned T   = T_DEFAULT,
  localparam int unsigned IDW = $clog2(T)
) (
  input  logic [T-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int unsigned off = 0; off < T; off++) begin
      idx = (32'(ptr) + off) % T;
      if (!gnt_valid && req[IDW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/teller_scheduler.sv
// Dispatches the queue front to an open, idle teller with round-robin fairness,
// spaces grants by HOLD cycles and tracks per-teller busy state with a timeout.
module teller_scheduler
  import teller_sched_pkg::*;
#(
  parameter  int unsigned N     = 3,
  parameter  int unsigned T     = 4,
  parameter  int unsigned SVC_W = 6,
  parameter  int unsigned HOLD  = 3,
  localparam int unsigned IDW   = $clog2(T)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             empty_flag,
  input  logic [T-1:0]     teller_en,
  input  logic [T-1:0]     teller_done,
  input  logic [SVC_W-1:0] svc_limit,
  output logic             dequeue,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic [T-1:0]     busy,
  output logic [T-1:0]     timeout,
  output logic [N-1:0]     Tcount
);

  localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

  ctrl_state_e    state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [N-1:0]   tcount_q, tcount_d;

  logic           arb_valid;
  logic [IDW-1:0] arb_id;

  rr_arbiter #(.T(T)) u_arb (
    .req       (teller_en & ~busy),
    .ptr       (ptr_q),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    grant_d    = 1'b0;
    grant_id_d = grant_id_q;
    tcount_d   = N'(popcount_sat(8'(teller_en), N));
    case (state_q)
      S_READY: begin
        if (!empty_flag && arb_valid) begin
          grant_d    = 1'b1;
          grant_id_d = arb_id;
          ptr_d      = (arb_id == IDW'(T - 1)) ? '0 : arb_id + 1'b1;
          state_d    = S_HOLD;
          hold_cnt_d = HCW'(HOLD - 1);
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = S_READY;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= S_READY;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
      grant_q    <= 1'b0;
      grant_id_q <= '0;
      tcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      tcount_q   <= tcount_d;
    end
  end

  for (genvar i = 0; i < T; i++) begin : g_teller
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [SVC_W-1:0] timer_q, timer_d;

    // Completion beats timeout; a fresh grant to this teller overrides both.
    always_comb begin
      busy_d    = busy_q;
      timer_d   = timer_q;
      timeout_d = 1'b0;
      if (busy_q) begin
        if (teller_done[i]) begin
          busy_d  = 1'b0;
          timer_d = '0;
        end else if (svc_limit != '0 && timer_q == svc_limit - 1'b1) begin
          busy_d    = 1'b0;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      if (grant_d && grant_id_d == IDW'(i)) begin
        busy_d  = 1'b1;
        timer_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset_n) begin
        busy_q    <= 1'b0;
        timeout_q <= 1'b0;
        timer_q   <= '0;
      end else begin
        busy_q    <= busy_d;
        timeout_q <= timeout_d;
        timer_q   <= timer_d;
      end
    end

    assign busy[i]    = busy_q;
    assign timeout[i] = timeout_q;
  end

  assign dequeue     = grant_q;
  assign grant_valid = grant_q;
  assign grant_id    = grant_id_q;
  assign Tcount      = tcount_q;

endmodule

// File: doc/teller_scheduler.md
Name: teller_scheduler

Overview:
- Dispatches the client at the front of the queue to one of T service tellers.
- Round-robin arbitration among open, idle tellers; one grant per dispatch.
- Issues the dequeue pulse that drives the queue's front-sensor input.
- Tracks per-teller busy state with a service timeout.
- Reports the open-teller count that feeds the wait-time lookup.

Parameters:
- N, 3, width of queue count and open-teller count.
- T, 4, number of tellers (2..8).
- SVC_W, 6, width of per-teller service timer and svc_limit.
- HOLD, 3, cycles between consecutive grants; lets the edge-detect/counter path update empty_flag.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-high reset; 1 resets on the next clk edge
- empty_flag  in  1  queue empty, from the queue counter
- teller_en  in  T  teller open (level)
- teller_done  in  T  1-cycle pulse: teller finished its client
- svc_limit  in  SVC_W  service timeout in cycles; 0 disables timeout
- dequeue  out  1  1-cycle pulse to the queue front input
- grant_valid  out  1  1-cycle pulse, coincident with dequeue
- grant_id  out  clog2(T)  teller granted; held until the next grant
- busy  out  T  teller serving a client
- timeout  out  T  1-cycle pulse: service timer expired
- Tcount  out  N  popcount(teller_en), saturated at 2^N-1, registered

Behaviour:
- Reset: dequeue=0, grant_valid=0, grant_id=0, busy=0, timeout=0, Tcount=0, all timers 0, rr pointer=0, control state READY, hold counter 0.
- Eligible teller i, evaluated in cycle k: teller_en[i]=1 and busy[i]=0 (registered values).
- READY state: if empty_flag=0 and any teller is eligible in cycle k, then at edge k+1:
  - dequeue=1, grant_valid=1, grant_id=w, busy[w]=1, timer[w]=0.
  - rr pointer = w+1 mod T.
  - state goes to HOLD, hold counter = HOLD-1.
- HOLD state: no grants; decrement once per cycle; at 0, return to READY. Minimum grant spacing is HOLD+1 cycles.
- Winner w: first eligible index searching upward from the rr pointer, wrapping at T-1 to 0.
- While busy[i]=1: timer[i] increments each cycle.
  - teller_done[i]=1 clears busy[i] next edge.
  - Otherwise, if svc_limit!=0 and timer[i]==svc_limit-1, clear busy[i] and pulse timeout[i].
  - teller_done and timeout coincide: done wins; no timeout pulse.
- teller_done[i] while busy[i]=0: ignored.
- A teller freed at edge k is eligible from cycle k onward; it is never re-granted in the same cycle its done pulse is sampled.
- teller_en[i] dropped while busy: the current service completes normally; the teller is not eligible until re-enabled.
- All tellers disabled or busy with a non-empty queue: stay in READY; no dequeue.
- empty_flag rises during HOLD: no effect; it is re-evaluated on return to READY.
- Tcount updates every cycle (1-cycle latency) and is independent of busy.
- Reset asserted mid-service or mid-HOLD: every state returns to its reset value at the next edge. No dequeue is issued on the reset edge.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package teller_sched_pkg holds:
  - the control state enum {READY, HOLD};
  - the constant TW = clog2(T);
  - a popcount-with-saturation function.
- Sub-module rr_arbiter (parameter T):
  - inputs req[T], ptr[TW];
  - outputs gnt_valid and gnt_id[TW];
  - purely combinational. Pointer update stays in the parent.
- Per-teller busy/timer logic is a generate loop in the parent, not a separate module.

Test Plan:
- Reset release, teller_en=4'b1111, empty_flag=0, HOLD=3: grants go to ids 0,1,2,3 on cycles 1,5,9,13; dequeue pulses align with grants; busy ends at 4'b1111; Tcount=4.
- teller_en=4'b0101, all idle, queue non-empty, pointer=1: first grant id=2, next grant id=0. Ids 1 and 3 are never granted.
- svc_limit=5 with no teller_done: busy[i] clears exactly 5 cycles after the grant, with one timeout[i] pulse. A second run with teller_done on cycle 5 gives no timeout pulse.
- All tellers busy with empty_flag=0: no dequeue. teller_done[2] at cycle k leads to a grant with id=2 at edge k+2 (eligible in cycle k+1, grant at k+2).
- empty_flag=1 with idle open tellers: dequeue never pulses. When empty_flag falls, a grant occurs on the next edge.
- reset_n=1 for one cycle during HOLD with busy=4'b0011: next edge busy=0, pointer=0, dequeue=0. The first grant after release is id=0.
